// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS memory stage:
//   - load/store opcode constants (OP_LB .. OP_SW)
//   - access-size encoding (SZ_BYTE / SZ_HALF / SZ_WORD) and its decoder
//   - the memory-stage FSM state type
//   - the MEM/WB output register layout
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef struct packed {
      size_e size;
      logic  is_signed;
   } access_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // MEM/WB register contents.
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        is_halt;
      logic [4:0]  wreg;
      logic [31:0] alu;
      logic [31:0] rdata;
   } wb_t;

   // Any opcode that is not a sub-word access behaves as a full word access.
   function automatic access_t decode_access(input logic [5:0] op);
      access_t a;
      case (op)
         OP_LB:        a = '{size: SZ_BYTE, is_signed: 1'b1};
         OP_LH:        a = '{size: SZ_HALF, is_signed: 1'b1};
         OP_LBU, OP_SB: a = '{size: SZ_BYTE, is_signed: 1'b0};
         OP_LHU, OP_SH: a = '{size: SZ_HALF, is_signed: 1'b0};
         OP_LW, OP_SW: a = '{size: SZ_WORD, is_signed: 1'b0};
         default:      a = '{size: SZ_WORD, is_signed: 1'b0};
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mem_stage_dram.sv
// -----------------------------------------------------------------------------
// mem_stage_dram
// Byte-enabled data RAM, 32-bit words, single address port.
//   clk      in   clock, rising edge
//   idx_i    in   word index
//   be_i     in   byte-lane write enables (lane 0 = bits 7:0)
//   wdata_i  in   write data, already steered onto the enabled lanes
//   rdata_o  out  read word: combinational for READ_LATENCY=1, otherwise the
//                 word read READ_LATENCY-1 cycles earlier (caller holds idx_i)
// A write at an edge is visible to a read in the following cycle.
// -----------------------------------------------------------------------------
module mem_stage_dram #(
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic                           clk,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
   input  logic [3:0]                     be_i,
   input  logic [31:0]                    wdata_i,
   output logic [31:0]                    rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   // NOTE: RAM contents are deliberately left without reset; clearing an
   // array needs a write port per word and software never relies on it.
   // NOTE: sequential state is always assigned with <= so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_comb_rd
         assign rdata_o = mem_q[idx_i];
      end else begin : g_pipe_rd
         logic [31:0] pipe_q [READ_LATENCY-1];
         always_ff @(posedge clk) begin
            pipe_q[0] <= mem_q[idx_i];
            for (int i = 1; i < READ_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
         assign rdata_o = pipe_q[READ_LATENCY-2];
      end
   endgenerate

endmodule

// File: rtl/mem_stage_mc.sv
// -----------------------------------------------------------------------------
// mem_stage_mc
// MIPS memory stage with internal data RAM and the MEM/WB output register.
// Loads with READ_LATENCY>1 stall upstream for READ_LATENCY-1 cycles.
//   clk, reset (async, active low)
//   valid_in, alu_result_in, write_data_in, write_register_in, reg_write_in,
//   mem_read_in, mem_write_in, mem_to_reg_in, opcode_in, is_halt_in : EX/MEM
//   stall_out          : upstream must hold its inputs this cycle
//   valid_out, read_data_out, alu_result_out, write_register_out,
//   reg_write_out, mem_to_reg_out, is_halt_out : MEM/WB register
//   read_data_out is 0 for anything that is not a load.
// Build option MEM_MISALIGN_TRAP_EN: adds misaligned_out; misaligned half/word
// accesses skip the RAM and never write a register. Without it, misaligned
// addresses are silently aligned down.
// -----------------------------------------------------------------------------
module mem_stage_mc
   import mips_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int MEM_DEPTH_WORDS = 256,
   parameter int READ_LATENCY    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] write_data_in,
   input  logic [4:0]        write_register_in,
   input  logic              reg_write_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic [5:0]        opcode_in,
   input  logic              is_halt_in,
   output logic              stall_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [4:0]        write_register_out,
   output logic              reg_write_out,
   output logic              mem_to_reg_out,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              misaligned_out,
`endif
   output logic              is_halt_out
);

   localparam int         IDX_W    = $clog2(MEM_DEPTH_WORDS);
   localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

   if (DATA_W != 32) begin : g_bad_width
      $error("mem_stage_mc: DATA_W must be 32");
   end
   if (MEM_DEPTH_WORDS < 4 || (MEM_DEPTH_WORDS & (MEM_DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("mem_stage_mc: MEM_DEPTH_WORDS must be a power of 2 >= 4");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
      $error("mem_stage_mc: READ_LATENCY must be 1..8");
   end

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   wb_t         wb_q, wb_d;
   access_t     acc;
   logic [1:0]  lane;
   logic        misaligned;
   logic        is_load, is_store, capture;
   logic [3:0]  be;
   logic [31:0] st_data, ram_rdata, ld_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign acc = decode_access(opcode_in);

   // Effective lane: sub-word bits that the access size cannot use are cleared.
   // NOTE: every always_comb assigns all of its outputs first so no path
   // leaves a variable unassigned, which would infer a latch.
   always_comb begin
      lane = alu_result_in[1:0];
      case (acc.size)
         SZ_HALF: lane[0] = 1'b0;
         SZ_WORD: lane    = 2'b00;
         default: ;
      endcase
   end

   // The aligned lane differs from the raw one exactly when the access is misaligned.
`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = valid_in && (mem_read_in || mem_write_in) && (lane != alu_result_in[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   assign is_store = valid_in && mem_write_in && !misaligned;
   assign is_load  = valid_in && mem_read_in && !mem_write_in && !misaligned;

   // Store steering: data replicated on every lane, enables pick the target.
   always_comb begin
      be      = 4'b0000;
      st_data = write_data_in;
      case (acc.size)
         SZ_BYTE: begin
            be[lane] = 1'b1;
            st_data  = {4{write_data_in[7:0]}};
         end
         SZ_HALF: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{write_data_in[15:0]}};
         end
         default: be = 4'b1111;
      endcase
      if (!(is_store && state_q == ST_IDLE)) be = 4'b0000;
   end

   mem_stage_dram #(
      .DEPTH_WORDS  (MEM_DEPTH_WORDS),
      .READ_LATENCY (READ_LATENCY)
   ) u_dram (
      .clk     (clk),
      .idx_i   (alu_result_in[IDX_W+1:2]),
      .be_i    (be),
      .wdata_i (st_data),
      .rdata_o (ram_rdata)
   );

   // Load extraction and sign/zero extension.
   always_comb begin
      ld_byte = ram_rdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (acc.size)
         SZ_BYTE: ld_ext = {{24{acc.is_signed & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_ext = {{16{acc.is_signed & ld_half[15]}}, ld_half};
         default: ld_ext = ram_rdata;
      endcase
   end

   // Stall FSM. capture=1 means the MEM/WB register takes the current
   // instruction; otherwise it takes a bubble.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_out = 1'b0;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (READ_LATENCY > 1 && is_load) begin
               stall_out = 1'b1;
               state_d   = ST_BUSY;
               cnt_d     = LAST_CNT;
            end else begin
               capture = 1'b1;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q > 4'd1) begin
               stall_out = 1'b1;
            end else begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wb_d = '0;
      if (capture && valid_in) begin
         wb_d.valid      = 1'b1;
         wb_d.reg_write  = reg_write_in && !misaligned;
         wb_d.mem_to_reg = mem_to_reg_in;
         wb_d.is_halt    = is_halt_in;
         wb_d.wreg       = write_register_in;
         wb_d.alu        = alu_result_in;
         wb_d.rdata      = is_load ? ld_ext : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wb_q    <= wb_d;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misaligned_q <= 1'b0;
      else        misaligned_q <= capture && misaligned;
   end
   assign misaligned_out = misaligned_q;
`endif

   assign valid_out          = wb_q.valid;
   assign reg_write_out      = wb_q.reg_write;
   assign mem_to_reg_out     = wb_q.mem_to_reg;
   assign is_halt_out        = wb_q.is_halt;
   assign write_register_out = wb_q.wreg;
   assign alu_result_out     = wb_q.alu;
   assign read_data_out      = wb_q.rdata;

endmodule

// File: tb/tb_mem_stage_mc.sv
`timescale 1ns/1ps
module tb_mem_stage_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, is_halt_in;
   logic [31:0] alu_result_in, write_data_in;
   logic [4:0]  write_register_in;
   logic [5:0]  opcode_in;

   logic        s1, v1, rw1, m2r1, h1;
   logic [31:0] rd1, alu1;
   logic [4:0]  wr1;
   logic        s4, v4, rw4, m2r4, h4;
   logic [31:0] rd4, alu4;
   logic [4:0]  wr4;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        mis1, mis4;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_stage_mc #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
      .write_data_in(write_data_in), .write_register_in(write_register_in),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .opcode_in(opcode_in), .is_halt_in(is_halt_in),
      .stall_out(s1), .valid_out(v1), .read_data_out(rd1), .alu_result_out(alu1),
      .write_register_out(wr1), .reg_write_out(rw1), .mem_to_reg_out(m2r1),
`ifdef MEM_MISALIGN_TRAP_EN
      .misaligned_out(mis1),
`endif
      .is_halt_out(h1)
   );

   mem_stage_mc #(.READ_LATENCY(4)) dut4 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
      .write_data_in(write_data_in), .write_register_in(write_register_in),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .opcode_in(opcode_in), .is_halt_in(is_halt_in),
      .stall_out(s4), .valid_out(v4), .read_data_out(rd4), .alu_result_out(alu4),
      .write_register_out(wr4), .reg_write_out(rw4), .mem_to_reg_out(m2r4),
`ifdef MEM_MISALIGN_TRAP_EN
      .misaligned_out(mis4),
`endif
      .is_halt_out(h4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rd, input logic wr,
                        input logic rw, input logic m2r, input logic [4:0] dst,
                        input logic halt);
      valid_in          = v;
      opcode_in         = op;
      alu_result_in     = addr;
      write_data_in     = wd;
      mem_read_in       = rd;
      mem_write_in      = wr;
      reg_write_in      = rw;
      mem_to_reg_in     = m2r;
      write_register_in = dst;
      is_halt_in        = halt;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   // Shorthands: store (no reg write) and load (reg write to r5).
   task automatic st(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
      drive(1'b1, op, addr, wd, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic ld(input logic [5:0] op, input logic [31:0] addr);
      drive(1'b1, op, addr, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      chk("rst_v1", v1, 0);   chk("rst_rd1", rd1, 0);   chk("rst_alu1", alu1, 0);
      chk("rst_rw1", rw1, 0); chk("rst_s1", s1, 0);     chk("rst_v4", v4, 0);
      chk("rst_s4", s4, 0);
      tick(); tick();
      reset = 1'b1;
      chk("post_rst_v1", v1, 0);

      // ---- latency 1 (dut1) ----
      st(6'h2B, 32'h10, 32'hDEADBEEF);
      chk("sw_stall", s1, 0);
      tick();
      chk("sw_v", v1, 1); chk("sw_rw", rw1, 0); chk("sw_alu", alu1, 32'h10);

      ld(6'h23, 32'h10);
      chk("lw_stall", s1, 0);
      tick();
      chk("lw_data", rd1, 32'hDEADBEEF); chk("lw_v", v1, 1); chk("lw_rw", rw1, 1);
      chk("lw_dst", wr1, 5); chk("lw_m2r", m2r1, 1);

      st(6'h28, 32'h13, 32'h00000080); tick();
      ld(6'h20, 32'h13); tick(); chk("lb_neg", rd1, 32'hFFFFFF80);
      ld(6'h24, 32'h13); tick(); chk("lbu", rd1, 32'h00000080);
      ld(6'h21, 32'h12); tick(); chk("lh_hi", rd1, 32'hFFFF80AD);
      ld(6'h25, 32'h10); tick(); chk("lhu_lo", rd1, 32'h0000BEEF);
      st(6'h29, 32'h16, 32'h0000_1234); tick();
      ld(6'h23, 32'h14); tick(); chk("sh_lane", rd1[31:16], 32'h1234);

      // wrap: word index ignores address bits above the RAM depth
      st(6'h2B, 32'h400, 32'h12345678); tick();
      ld(6'h23, 32'h0); tick(); chk("wrap", rd1, 32'h12345678);

      // bubble: no RAM write even though mem_write_in is set
      drive(1'b0, 6'h2B, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0);
      tick();
      chk("bub_v", v1, 0); chk("bub_rw", rw1, 0);
      ld(6'h23, 32'h0); tick(); chk("bub_nowr", rd1, 32'h12345678);

      // read and write together: the store wins
      st(6'h2B, 32'h20, 32'h11111111); tick();
      drive(1'b1, 6'h2B, 32'h20, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      chk("rw_both_rd", rd1, 0);
      ld(6'h23, 32'h20); tick(); chk("rw_both_st", rd1, 32'hCAFEF00D);

      // misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
      ld(6'h23, 32'h11); tick();
      chk("mis_flag", mis1, 1); chk("mis_v", v1, 1); chk("mis_rw", rw1, 0);
      st(6'h2B, 32'h11, 32'h0); tick();
      chk("mis_st_flag", mis1, 1);
      idle(); tick(); chk("mis_clear", mis1, 0);
      ld(6'h23, 32'h10); tick(); chk("mis_ram", rd1, 32'h80ADBEEF);
`else
      ld(6'h23, 32'h11); tick();
      chk("mis_align", rd1, 32'h80ADBEEF); chk("mis_rw", rw1, 1);
`endif

      // non-memory instruction carrying HALT
      drive(1'b1, 6'h00, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1);
      tick();
      chk("halt_h", h1, 1); chk("halt_alu", alu1, 32'h55); chk("halt_dst", wr1, 9);

      // ---- latency 4 (dut4) ----
      idle();
      repeat (8) tick();
      st(6'h2B, 32'h10, 32'hDEADBEEF);
      chk("l4_sw_stall", s4, 0);
      tick();
      drive(1'b1, 6'h23, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
      chk("l4_stall_T", s4, 1);
      tick();
      chk("l4_stall_T1", s4, 1); chk("l4_v_T1", v4, 0); chk("l4_rw_T1", rw4, 0);
      chk("l4_h_T1", h4, 0);
      tick();
      chk("l4_stall_T2", s4, 1); chk("l4_v_T2", v4, 0);
      tick();
      chk("l4_stall_T3", s4, 0); chk("l4_v_T3", v4, 0);
      tick();
      idle();
      chk("l4_data", rd4, 32'hDEADBEEF); chk("l4_v", v4, 1); chk("l4_rw", rw4, 1);
      chk("l4_h", h4, 1); chk("l4_dst", wr4, 7); chk("l4_stall_T4", s4, 0);
      tick();
      chk("l4_after", v4, 0);

      // reset in the middle of a 4-cycle load
      ld(6'h23, 32'h10);
      tick();
      chk("mid_s4", s4, 1); chk("mid_v1", v1, 1); chk("mid_rd1", rd1, 32'hDEADBEEF);
      reset = 1'b0;
      idle();
      chk("mid_rst_v1", v1, 0); chk("mid_rst_rd1", rd1, 0); chk("mid_rst_alu1", alu1, 0);
      chk("mid_rst_rw1", rw1, 0); chk("mid_rst_s4", s4, 0); chk("mid_rst_v4", v4, 0);
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no_wb_v4", v4, 0);
         chk("no_wb_s4", s4, 0);
      end
      ld(6'h23, 32'h10);
      chk("retain_stall", s4, 1);
      repeat (4) tick();
      idle();
      chk("retain_data", rd4, 32'hDEADBEEF); chk("retain_v", v4, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
